// File: rtl/dft_cos_accum.sv
// Real DFT bin accumulator downstream of the stalling cos pipeline: multiplies each
// sample by its cos value, sums N terms (or fewer on in_last), and presents the result on a valid/ready port.
module dft_cos_accum #(
  parameter int unsigned LAT      = 2,
  parameter int unsigned COS_W    = 37,
  parameter int unsigned COS_FRAC = 35,
  parameter int unsigned SMP_W    = 32,
  parameter int unsigned ACC_W    = 48,
  parameter int unsigned N        = 64,
  localparam int unsigned CNT_W   = $clog2(N + 1)
) (
  input  logic             aclk,
  input  logic             arst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SMP_W-1:0] in_sample,
  input  logic             in_last,
  input  logic [COS_W-1:0] cos_x,
  output logic             astall,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [CNT_W-1:0] out_cnt
);

  localparam int unsigned PROD_W = SMP_W + COS_W;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD} state_t;

  state_t           state_q, state_d;
  logic [SMP_W-1:0] smp_q [LAT];
  logic [SMP_W-1:0] smp_d [LAT];
  logic             vld_q [LAT];
  logic             vld_d [LAT];
  logic             lst_q [LAT];
  logic             lst_d [LAT];
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;

  logic                     en_c;
  logic                     fire_c;
  logic                     frame_end_c;
  logic signed [PROD_W-1:0] prod_c;
  logic [ACC_W-1:0]         term_c;
  logic [ACC_W-1:0]         sum_c;
  logic [CNT_W-1:0]         count_n_c;

  // The only stall source: a result is waiting and the consumer is not taking it.
  assign astall    = (state_q == S_HOLD) & ~out_ready;
  assign in_ready  = ~astall;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_cnt   = out_cnt_q;

  // Term arithmetic: full-width signed product, floor by arithmetic shift, then fit to ACC_W.
  always_comb begin
    prod_c    = PROD_W'($signed(smp_q[LAT-1])) * PROD_W'($signed(cos_x));
    term_c    = ACC_W'(prod_c >>> COS_FRAC);
    sum_c     = acc_q + term_c;
    count_n_c = count_q + CNT_W'(1);
  end

  always_comb begin
    en_c        = ~astall;
    fire_c      = en_c & vld_q[LAT-1];
    frame_end_c = fire_c & (lst_q[LAT-1] | (count_n_c == CNT_W'(N)));

    smp_d       = smp_q;
    vld_d       = vld_q;
    lst_d       = lst_q;
    acc_d       = acc_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_cnt_d   = out_cnt_q;
    state_d     = state_q;

    // Shadow pipe moves in lockstep with the cos pipeline.
    if (en_c) begin
      smp_d[0] = in_sample;
      vld_d[0] = in_valid;
      lst_d[0] = in_last;
      for (int i = 1; i < LAT; i++) begin
        smp_d[i] = smp_q[i-1];
        vld_d[i] = vld_q[i-1];
        lst_d[i] = lst_q[i-1];
      end
    end

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (fire_c) begin
      if (frame_end_c) begin
        out_data_d  = sum_c;
        out_cnt_d   = count_n_c;
        out_valid_d = 1'b1;
        acc_d       = '0;
        count_d     = '0;
      end else begin
        acc_d   = sum_c;
        count_d = count_n_c;
      end
    end

    // HOLD means a result is pending; it only freezes the datapath while out_ready is low.
    if (out_valid_d)             state_d = S_HOLD;
    else if (count_d != '0)      state_d = S_ACCUM;
    else                         state_d = S_IDLE;
  end

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= S_IDLE;
      for (int i = 0; i < LAT; i++) begin
        smp_q[i] <= '0;
        vld_q[i] <= 1'b0;
        lst_q[i] <= 1'b0;
      end
      acc_q       <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      smp_q       <= smp_d;
      vld_q       <= vld_d;
      lst_q       <= lst_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_cnt_q   <= out_cnt_d;
    end
  end

endmodule

// File: tb/tb_dft_cos_accum.sv
// Directed bench for dft_cos_accum (N=4, LAT=2) with a bench-side cos pipe and a result scoreboard.
module tb_dft_cos_accum;

  localparam int unsigned LAT   = 2;
  localparam int unsigned COS_W = 37;
  localparam int unsigned SMP_W = 32;
  localparam int unsigned ACC_W = 48;
  localparam int unsigned N     = 4;
  localparam int unsigned CNT_W = 3;

  localparam logic [COS_W-1:0] C_P1   = 37'h08_0000_0000;
  localparam logic [COS_W-1:0] C_M1   = 37'h18_0000_0000;
  localparam logic [COS_W-1:0] C_HALF = 37'h04_0000_0000;

  typedef struct packed {
    logic [ACC_W-1:0] data;
    logic [CNT_W-1:0] cnt;
  } res_t;

  logic             aclk;
  logic             arst_n;
  logic             in_valid;
  logic             in_ready;
  logic [SMP_W-1:0] in_sample;
  logic             in_last;
  logic [COS_W-1:0] cos_x;
  logic             astall;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic [CNT_W-1:0] out_cnt;

  logic [COS_W-1:0] cos_in;
  logic [COS_W-1:0] cos_pipe [LAT];

  res_t             sb [$];
  logic [ACC_W-1:0] m_acc;
  int               m_cnt;
  int               checks;
  int               errors;

  dft_cos_accum #(
    .LAT(LAT), .COS_W(COS_W), .COS_FRAC(35), .SMP_W(SMP_W), .ACC_W(ACC_W), .N(N)
  ) dut (
    .aclk(aclk), .arst_n(arst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sample(in_sample), .in_last(in_last), .cos_x(cos_x), .astall(astall),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_cnt(out_cnt)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  // Stand-in for the upstream cos pipeline: same depth, same stall.
  always @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      cos_pipe[0] <= '0;
      cos_pipe[1] <= '0;
    end else if (in_ready) begin
      cos_pipe[0] <= cos_in;
      cos_pipe[1] <= cos_pipe[0];
    end
  end
  assign cos_x = cos_pipe[LAT-1];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // floor(s*c / 2^35) by truncating division plus correction for negative remainders.
  function automatic logic [ACC_W-1:0] model_term(input logic [SMP_W-1:0] s, input logic [COS_W-1:0] c);
    logic signed [127:0] p, q, dv;
    dv = 128'sh8_0000_0000;
    p  = 128'($signed(s)) * 128'($signed(c));
    q  = p / dv;
    if (p < 0 && (q * dv) != p) q = q - 1;
    return q[ACC_W-1:0];
  endfunction

  task automatic model_accept(input logic [SMP_W-1:0] s, input logic [COS_W-1:0] c, input logic l);
    res_t r;
    m_acc = m_acc + model_term(s, c);
    m_cnt++;
    if (l || m_cnt == int'(N)) begin
      r.data = m_acc;
      r.cnt  = CNT_W'(m_cnt);
      sb.push_back(r);
      m_acc = '0;
      m_cnt = 0;
    end
  endtask

  task automatic send(input logic [SMP_W-1:0] s, input logic [COS_W-1:0] c, input logic l);
    int waits;
    @(negedge aclk); #1;
    in_valid  = 1'b1;
    in_sample = s;
    cos_in    = c;
    in_last   = l;
    #1;
    waits = 0;
    while (!in_ready && waits < 50) begin
      @(negedge aclk); #2;
      waits++;
    end
    chk("send_accept", 64'(in_ready), 64'd1);
    if (in_ready) model_accept(s, c, l);
  endtask

  task automatic idle();
    @(negedge aclk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Scoreboard: every handshake pops the oldest expected bin.
  always @(negedge aclk) begin
    res_t e;
    #3;
    if (arst_n && out_valid && out_ready) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL sb_empty: observed result %0h with no expected entry", out_data);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("out_data", 64'(out_data), 64'(e.data));
        chk("out_cnt", 64'(out_cnt), 64'(e.cnt));
      end
    end
  end

  initial begin
    checks = 0; errors = 0;
    m_acc = '0; m_cnt = 0;
    arst_n = 1'b0; in_valid = 1'b0; in_sample = '0; in_last = 1'b0;
    cos_in = '0; out_ready = 1'b1;
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_cnt", 64'(out_cnt), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_astall", 64'(astall), 64'd0);
    @(negedge aclk); #1 arst_n = 1'b1;

    // 1: four unit-cos terms ending on count==N, with latency check
    send(32'd1, C_P1, 1'b0);
    send(32'd2, C_P1, 1'b0);
    send(32'd3, C_P1, 1'b0);
    send(32'd4, C_P1, 1'b0);
    idle();
    @(posedge aclk); #1;
    chk("lat_before", 64'(out_valid), 64'd0);
    @(posedge aclk); #1;
    chk("lat_at", 64'(out_valid), 64'd1);
    chk("t1_data", 64'(out_data), 64'd10);
    @(posedge aclk); #1;
    chk("lat_pulse_end", 64'(out_valid), 64'd0);

    // 2: alternating sign cancels; half-cos floors each term; early in_last
    send(32'd100, C_P1, 1'b0);
    send(32'd100, C_M1, 1'b0);
    send(32'd100, C_P1, 1'b0);
    send(32'd100, C_M1, 1'b0);
    send(32'd3, C_HALF, 1'b0);
    send(32'd3, C_HALF, 1'b0);
    send(32'd3, C_HALF, 1'b0);
    send(32'd3, C_HALF, 1'b0);
    send(32'd9, C_P1, 1'b0);
    send(-32'sd4, C_P1, 1'b1);
    // 3: single-term bin with negative floor
    send(-32'sd3, C_HALF, 1'b1);
    idle();
    repeat (4) @(posedge aclk);
    #1;
    chk("t3_data", 64'(out_data), 64'(48'hFFFF_FFFF_FFFE));
    chk("t3_cnt", 64'(out_cnt), 64'd1);

    // 4: consumer stalls while the next bin is in flight
    out_ready = 1'b0;
    send(32'd5, C_P1, 1'b0);
    send(32'd6, C_P1, 1'b0);
    send(32'd7, C_P1, 1'b0);
    send(32'd8, C_P1, 1'b0);
    send(32'd10, C_P1, 1'b0);
    send(32'd20, C_P1, 1'b0);
    @(negedge aclk); #1;
    in_valid = 1'b1; in_sample = 32'd30; cos_in = C_P1; in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk); #2;
      chk("stall_astall", 64'(astall), 64'd1);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_data", 64'(out_data), 64'd26);
      chk("stall_cnt", 64'(out_cnt), 64'd4);
    end
    out_ready = 1'b1;
    #1;
    chk("unstall_in_ready", 64'(in_ready), 64'd1);
    model_accept(32'd30, C_P1, 1'b0);
    send(32'd40, C_P1, 1'b0);
    idle();
    repeat (4) @(posedge aclk);
    #1;
    chk("t4_next_bin", 64'(out_data), 64'd100);

    // 5: a frame end every cycle keeps out_valid high with no bubbles
    for (int k = 11; k <= 16; k++) send(32'(k), C_P1, 1'b1);
    idle();
    #1;
    chk("b2b_valid0", 64'(out_valid), 64'd1);
    @(negedge aclk); #2;
    chk("b2b_valid1", 64'(out_valid), 64'd1);
    @(negedge aclk); #2;
    chk("b2b_valid2", 64'(out_valid), 64'd1);
    @(negedge aclk); #2;
    chk("b2b_drop", 64'(out_valid), 64'd0);
    chk("b2b_drained", 64'(sb.size()), 64'd0);

    // 6: async reset mid-frame discards the partial sum
    send(32'd7, C_P1, 1'b0);
    send(32'd8, C_P1, 1'b0);
    idle();
    repeat (3) @(posedge aclk);
    @(negedge aclk); #2;
    arst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_data", 64'(out_data), 64'd0);
    chk("arst_cnt", 64'(out_cnt), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    m_acc = '0; m_cnt = 0;
    sb.delete();
    @(negedge aclk); #1 arst_n = 1'b1;
    send(32'd2, C_P1, 1'b0);
    send(32'd4, C_P1, 1'b0);
    send(32'd6, C_P1, 1'b0);
    send(32'd8, C_P1, 1'b0);
    idle();
    repeat (4) @(posedge aclk);
    #1;
    chk("post_rst_data", 64'(out_data), 64'd20);
    chk("post_rst_cnt", 64'(out_cnt), 64'd4);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge aclk);
    chk("final_drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
